reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Write-side counterpart of the decode-stage RAW hazard check. Tracks in-flight
//  destination registers between issue and writeback.
//  - Marks a register busy when an instruction issues.
//  - Clears the mark when the result writes back.
//  - Holds issue while a source register is still pending.
//  Sits between decode and execute. Drives the issue handshake and provides
//  occupancy and stall statistics for the fetch/decode pipeline.
// PARAMETERS
//  NUM_REGS  32  number of architectural registers tracked; equals the range of reg_t
//  CNT_W     2   width of each per-register pending-writer counter (max 2**CNT_W-1)
//  STALL_W   16  width of the saturating stall-cycle counter
// PORTS
//  clk              in   1                        clock; all state updates on rising edge
//  rst              in   1                        synchronous reset, active-high
//  issue_valid_i    in   1                        decode presents an instruction
//  issue_ready_o    out  1                        scoreboard accepts it this cycle
//  issue_opcode_i   in   alu_opcode_t             opcode of presented instruction
//  issue_src1_i     in   reg_t                    source register 1
//  issue_src2_i     in   reg_t                    source register 2
//  issue_dst_i      in   reg_t                    destination register
//  wb_valid_i       in   1                        a result writes back this cycle
//  wb_dst_i         in   reg_t                    register being written back
//  flush_i          in   1                        discard all in-flight tracking
//  stall_o          out  1                        issue_valid_i && !issue_ready_o
//  inflight_o       out  $clog2(NUM_REGS*(2**CNT_W-1)+1)  sum of all pending counters
//  stall_cnt_o      out  STALL_W                  stall cycles seen, saturating
//  wb_err_o         out  1                        sticky: writeback to a non-pending register
// BEHAVIOUR
//  Reset
//  - rst=1 on a rising edge clears all counters, inflight_o, stall_cnt_o and wb_err_o.
//  - While rst=1, issue_ready_o=0 and stall_o=0.
//  - rst mid-operation discards all pending state with no writeback required.
//  State
//  - pend[r] is a CNT_W-bit counter per register. busy[r] = (pend[r]!=0).
//  Ready (combinational from registered pend and current inputs, no forwarding)
//  - op_none: ready=1 always.
//  - op_add: ready = !busy[src1] && !busy[src2] && (pend[dst] != max).
//  - Any other opcode: ready = (pend[dst] != max).
//  - ready=0 whenever flush_i=1 or rst=1.
//  - A same-cycle writeback does not release a stall; the instruction issues the following cycle.
//  Fire and writeback
//  - fire = issue_valid_i && issue_ready_o && (issue_opcode_i != op_none).
//  - On fire: pend[dst]+1 next cycle.
//  - On wb_valid_i: if pend[wb_dst]!=0 then pend[wb_dst]-1; else the counter is unchanged and wb_err_o is set.
//  - fire and wb to the same register in the same cycle: pend is unchanged, no error, even when pend was 0.
//  - fire and wb to different registers: both updates apply.
//  - inflight_o tracks sum(pend), registered, same cycle as the pend update.
//  Flush
//  - flush_i=1 clears all pend and inflight_o next cycle and overrides fire and wb that cycle.
//  - wb_err_o and stall_cnt_o are unaffected by flush.
//  Statistics
//  - stall_cnt_o increments by 1 each cycle stall_o=1.
//  - stall_cnt_o saturates at all-ones and does not wrap.
//  - wb_err_o clears only on rst.
//  Latency
//  - Busy is visible to the next instruction 1 cycle after fire.
//  - Release is visible 1 cycle after wb.
// TESTING
//  1. Reset: hold rst 2 cycles -> issue_ready_o=0, inflight_o=0, stall_cnt_o=0, wb_err_o=0.
//     Release rst with op_none valid -> ready=1.
//  2. RAW hazard:
//     - Issue add dst=5.
//     - Next cycle add src1=5 -> stall_o=1.
//     - wb dst=5 at cycle 4 -> ready=1 at cycle 5.
//     - stall_cnt_o=3.
//  3. Counter saturation and WAW:
//     - Issue 3 adds with dst=7 (CNT_W=2) -> inflight_o=3.
//     - 4th add dst=7 -> stalled.
//     - One wb dst=7 -> 4th issues next cycle.
//  4. Simultaneous fire and wb to r9 with pend[9]=1 -> pend[9] stays 1, inflight_o unchanged.
//     Same with pend=0 -> no wb_err_o.
//  5. Spurious wb: wb dst=3 with pend[3]=0 -> wb_err_o=1, held until rst.
//     The next flush leaves it 1.
//  6. Flush: pend[1]=2, pend[4]=1, plus fire dst=8 and wb dst=1 in the flush cycle.
//     -> Next cycle inflight_o=0 and all registers ready.
//     Also cover stall_cnt_o saturation with STALL_W=4 held 20 cycles -> 15.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Shared types and the decode/scoreboard issue+writeback interface.
package reg_scoreboard_pkg;
  typedef logic [4:0] reg_t;
  typedef enum logic [2:0] {
    op_none = 3'd0,
    op_add  = 3'd1,
    op_sub  = 3'd2,
    op_and  = 3'd3,
    op_or   = 3'd4,
    op_ld   = 3'd5
  } alu_opcode_t;
endpackage

interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic        issue_valid_i;
  logic        issue_ready_o;
  alu_opcode_t issue_opcode_i;
  reg_t        issue_src1_i;
  reg_t        issue_src2_i;
  reg_t        issue_dst_i;
  logic        wb_valid_i;
  reg_t        wb_dst_i;
  logic        flush_i;

  // Decode side drives issue/writeback/flush, sees ready.
  modport master (
    output issue_valid_i, issue_opcode_i, issue_src1_i, issue_src2_i, issue_dst_i,
    output wb_valid_i, wb_dst_i, flush_i,
    input  issue_ready_o
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid_i, issue_opcode_i, issue_src1_i, issue_src2_i, issue_dst_i,
    input  wb_valid_i, wb_dst_i, flush_i,
    output issue_ready_o
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-writer counters gating issue,
// with in-flight occupancy, stall statistics and a sticky spurious-writeback flag.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned STALL_W  = 16,
  localparam int unsigned INFL_W  = $clog2(NUM_REGS * (2**CNT_W - 1) + 1)
) (
  input  logic               clk,
  input  logic               rst,
  reg_scoreboard_if.slave    sb,
  output logic               stall_o,
  output logic [INFL_W-1:0]  inflight_o,
  output logic [STALL_W-1:0] stall_cnt_o,
  output logic               wb_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   r_pend [NUM_REGS];
  logic [INFL_W-1:0]  r_inflight;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_wb_err;

  logic                w_ready;
  logic                w_fire;
  logic                w_same;
  logic                w_inc;
  logic                w_dec;
  logic                w_err;
  logic [NUM_REGS-1:0] w_inc_vec;
  logic [NUM_REGS-1:0] w_dec_vec;

  // Issue readiness from registered pend state only (no writeback forwarding).
  always_comb begin
    w_ready = 1'b0;
    if (!rst && !sb.flush_i) begin
      case (sb.issue_opcode_i)
        op_none: w_ready = 1'b1;
        op_add:  w_ready = (r_pend[sb.issue_src1_i] == '0) &&
                           (r_pend[sb.issue_src2_i] == '0) &&
                           (r_pend[sb.issue_dst_i] != CNT_MAX);
        default: w_ready = (r_pend[sb.issue_dst_i] != CNT_MAX);
      endcase
    end
  end

  assign sb.issue_ready_o = w_ready;
  assign stall_o          = sb.issue_valid_i && !w_ready && !rst;

  // Per-register increment/decrement; fire and wb to one register cancel out.
  always_comb begin
    w_fire    = sb.issue_valid_i && w_ready && (sb.issue_opcode_i != op_none);
    w_same    = w_fire && sb.wb_valid_i && (sb.issue_dst_i == sb.wb_dst_i);
    w_inc     = w_fire && !w_same;
    w_dec     = sb.wb_valid_i && !w_same && (r_pend[sb.wb_dst_i] != '0);
    w_err     = sb.wb_valid_i && !w_same && (r_pend[sb.wb_dst_i] == '0);
    w_inc_vec = '0;
    w_dec_vec = '0;
    w_inc_vec[sb.issue_dst_i] = w_inc;
    w_dec_vec[sb.wb_dst_i]    = w_dec;
  end

  // Pending counters, occupancy, stall statistics and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) r_pend[r] <= '0;
      r_inflight  <= '0;
      r_stall_cnt <= '0;
      r_wb_err    <= 1'b0;
    end else begin
      if (stall_o && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      if (sb.flush_i) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) r_pend[r] <= '0;
        r_inflight <= '0;
      end else begin
        for (int unsigned r = 0; r < NUM_REGS; r++)
          r_pend[r] <= r_pend[r] + CNT_W'(w_inc_vec[r]) - CNT_W'(w_dec_vec[r]);
        r_inflight <= r_inflight + INFL_W'(w_inc) - INFL_W'(w_dec);
        if (w_err) r_wb_err <= 1'b1;
      end
    end
  end

  assign inflight_o  = r_inflight;
  assign stall_cnt_o = r_stall_cnt;
  assign wb_err_o    = r_wb_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus randomized traffic,
// every cycle compared against an array-based model of the pending counts.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int unsigned NREG  = 32;
  localparam int unsigned CW    = 2;
  localparam int unsigned SW    = 4;
  localparam int unsigned IW    = $clog2(NREG * (2**CW - 1) + 1);
  localparam int          PMAX  = 3;
  localparam int          SMAX  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_o;
  logic [IW-1:0] inflight_o;
  logic [SW-1:0] stall_cnt_o;
  logic          wb_err_o;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(.NUM_REGS(NREG), .CNT_W(CW), .STALL_W(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sb          (sb_if.slave),
    .stall_o     (stall_o),
    .inflight_o  (inflight_o),
    .stall_cnt_o (stall_cnt_o),
    .wb_err_o    (wb_err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state
  int m_pend [NREG];
  int m_stall_cnt = 0;
  int m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_sum();
    int s = 0;
    for (int i = 0; i < NREG; i++) s += m_pend[i];
    return s;
  endfunction

  function automatic int m_ready();
    int s1, s2, d;
    s1 = int'(sb_if.issue_src1_i);
    s2 = int'(sb_if.issue_src2_i);
    d  = int'(sb_if.issue_dst_i);
    if (rst || sb_if.flush_i) return 0;
    if (sb_if.issue_opcode_i == op_none) return 1;
    if (sb_if.issue_opcode_i == op_add)
      return (m_pend[s1] == 0 && m_pend[s2] == 0 && m_pend[d] != PMAX) ? 1 : 0;
    return (m_pend[d] != PMAX) ? 1 : 0;
  endfunction

  // Apply inputs (called just after a falling edge), then check the combinational outputs.
  task automatic drive(input bit r, input bit v, input alu_opcode_t op,
                       input int s1, input int s2, input int d,
                       input bit wbv, input int wbd, input bit fl);
    int er;
    rst                  = r;
    sb_if.issue_valid_i  = v;
    sb_if.issue_opcode_i = op;
    sb_if.issue_src1_i   = reg_t'(s1);
    sb_if.issue_src2_i   = reg_t'(s2);
    sb_if.issue_dst_i    = reg_t'(d);
    sb_if.wb_valid_i     = wbv;
    sb_if.wb_dst_i       = reg_t'(wbd);
    sb_if.flush_i        = fl;
    #1;
    er = m_ready();
    chk("ready", int'(sb_if.issue_ready_o), er);
    chk("stall", int'(stall_o), (v && !er && !r) ? 1 : 0);
  endtask

  // Advance one clock, update the model, check registered outputs at the falling edge.
  task automatic tick();
    int d, wbd, er, fire;
    @(posedge clk);
    d   = int'(sb_if.issue_dst_i);
    wbd = int'(sb_if.wb_dst_i);
    er  = m_ready();
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_pend[i] = 0;
      m_stall_cnt = 0;
      m_err = 0;
    end else begin
      if (sb_if.issue_valid_i && !er && m_stall_cnt < SMAX) m_stall_cnt++;
      if (sb_if.flush_i) begin
        for (int i = 0; i < NREG; i++) m_pend[i] = 0;
      end else begin
        fire = (sb_if.issue_valid_i && er && sb_if.issue_opcode_i != op_none) ? 1 : 0;
        if (!(fire && sb_if.wb_valid_i && d == wbd)) begin
          if (fire) m_pend[d]++;
          if (sb_if.wb_valid_i) begin
            if (m_pend[wbd] > 0) m_pend[wbd]--;
            else m_err = 1;
          end
        end
      end
    end
    @(negedge clk);
    chk("inflight", int'(inflight_o), m_sum());
    chk("stall_cnt", int'(stall_cnt_o), m_stall_cnt);
    chk("wb_err", int'(wb_err_o), m_err);
  endtask

  task automatic idle();
    drive(0, 0, op_none, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, op_none, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic issue_add(input int s1, input int s2, input int d);
    drive(0, 1, op_add, s1, s2, d, 0, 0, 0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) m_pend[i] = 0;

    // Reset held two cycles with op_none presented
    drive(1, 1, op_none, 0, 0, 0, 0, 0, 0);
    chk("t1_ready_in_rst", int'(sb_if.issue_ready_o), 0);
    chk("t1_stall_in_rst", int'(stall_o), 0);
    tick();
    drive(1, 1, op_none, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t1_inflight", int'(inflight_o), 0);
    chk("t1_stall_cnt", int'(stall_cnt_o), 0);
    chk("t1_wb_err", int'(wb_err_o), 0);
    drive(0, 1, op_none, 0, 0, 0, 0, 0, 0);
    chk("t1_ready_after_rst", int'(sb_if.issue_ready_o), 1);
    tick();

    // RAW hazard on r5: three stall cycles, wb in the third does not release it
    issue_add(0, 0, 5);
    drive(0, 1, op_add, 5, 0, 6, 0, 0, 0);
    chk("t2_stall_c2", int'(stall_o), 1);
    tick();
    drive(0, 1, op_add, 5, 0, 6, 0, 0, 0);
    tick();
    drive(0, 1, op_add, 5, 0, 6, 1, 5, 0);
    chk("t2_stall_c4_wb", int'(stall_o), 1);
    tick();
    drive(0, 1, op_add, 5, 0, 6, 0, 0, 0);
    chk("t2_ready_c5", int'(sb_if.issue_ready_o), 1);
    chk("t2_stall_cnt", int'(stall_cnt_o), 3);
    tick();
    chk("t2_inflight", int'(inflight_o), 1);

    // WAW saturation on r7
    do_reset();
    issue_add(0, 0, 7);
    issue_add(0, 0, 7);
    issue_add(0, 0, 7);
    chk("t3_inflight3", int'(inflight_o), 3);
    drive(0, 1, op_add, 0, 0, 7, 0, 0, 0);
    chk("t3_sat_stall", int'(sb_if.issue_ready_o), 0);
    tick();
    drive(0, 1, op_add, 0, 0, 7, 1, 7, 0);
    chk("t3_wb_same_cycle", int'(sb_if.issue_ready_o), 0);
    tick();
    chk("t3_inflight2", int'(inflight_o), 2);
    drive(0, 1, op_add, 0, 0, 7, 0, 0, 0);
    chk("t3_ready_after_wb", int'(sb_if.issue_ready_o), 1);
    tick();
    chk("t3_inflight_back3", int'(inflight_o), 3);

    // Simultaneous fire and wb to r9
    do_reset();
    issue_add(0, 0, 9);
    drive(0, 1, op_sub, 0, 0, 9, 1, 9, 0);
    tick();
    chk("t4_inflight_p1", int'(inflight_o), 1);
    drive(0, 0, op_none, 0, 0, 0, 1, 9, 0);
    tick();
    chk("t4_inflight_p0", int'(inflight_o), 0);
    drive(0, 1, op_sub, 0, 0, 9, 1, 9, 0);
    tick();
    chk("t4_inflight_same0", int'(inflight_o), 0);
    chk("t4_no_err", int'(wb_err_o), 0);

    // Spurious writeback is sticky across flush
    do_reset();
    drive(0, 0, op_none, 0, 0, 0, 1, 3, 0);
    tick();
    chk("t5_err_set", int'(wb_err_o), 1);
    drive(0, 0, op_none, 0, 0, 0, 0, 0, 1);
    tick();
    chk("t5_err_after_flush", int'(wb_err_o), 1);

    // Flush overrides same-cycle fire and writeback
    do_reset();
    issue_add(0, 0, 1);
    issue_add(0, 0, 1);
    issue_add(0, 0, 4);
    chk("t6_inflight3", int'(inflight_o), 3);
    drive(0, 1, op_add, 0, 0, 8, 1, 1, 1);
    chk("t6_ready_flush", int'(sb_if.issue_ready_o), 0);
    tick();
    chk("t6_inflight0", int'(inflight_o), 0);
    chk("t6_err_clear", int'(wb_err_o), 0);
    drive(0, 1, op_add, 1, 4, 8, 0, 0, 0);
    chk("t6_ready_all", int'(sb_if.issue_ready_o), 1);
    tick();

    // Stall counter saturation (4-bit)
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, op_add, 0, 0, 2, 0, 0, 1);
      tick();
    end
    chk("t7_stall_sat", int'(stall_cnt_o), 15);

    // Randomized traffic over a small register window to provoke hazards
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit r, v, wbv, fl;
      alu_opcode_t op;
      r   = ($urandom_range(0, 99) < 2);
      fl  = ($urandom_range(0, 99) < 3);
      v   = ($urandom_range(0, 99) < 75);
      wbv = ($urandom_range(0, 99) < 45);
      op  = alu_opcode_t'($urandom_range(0, 5));
      drive(r, v, op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            wbv, $urandom_range(0, 7), fl);
      tick();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
